// File: rtl/rx_work_assembler_pkg.sv
// rx_work_assembler_pkg
// Shared definitions for the receive-side work assembler: the default unit
// size, the two-state FSM encoding and the byte-counter width helper.
package rx_work_assembler_pkg;

    localparam int WORK_BYTES_DEF = 64;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    // Width of a counter that must reach WORK_BYTES inclusive
    function automatic int byteCntWidth(input int workBytes);
        return $clog2(workBytes + 1);
    endfunction

endpackage

// File: rtl/rx_work_assembler_if.sv
// rx_work_assembler_if
// Valid/ready handshake carrying one assembled work unit to the hash core.
//   work_valid : unit in work_data is complete
//   work_ready : consumer accepts the unit when high with work_valid
//   work_data  : assembled unit, first received byte in the MS byte
// master = assembler side, slave = hash-core side.
interface rx_work_assembler_if #(
    parameter int WORK_BYTES = rx_work_assembler_pkg::WORK_BYTES_DEF
);
    logic                    work_valid;
    logic                    work_ready;
    logic [8*WORK_BYTES-1:0] work_data;

    modport master (output work_valid, output work_data, input  work_ready);
    modport slave  (input  work_valid, input  work_data, output work_ready);
endinterface

// File: rtl/rx_work_assembler_sat_counter.sv
// sat_counter
// Registered CNT_W-bit counter that adds an 8-bit increment when enabled and
// clamps at all-ones instead of wrapping.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_en       : add i_inc this cycle
//   i_inc      : increment amount
//   o_count    : current saturated count
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [7:0]       i_inc,
    output logic [CNT_W-1:0] o_count
);
    // One spare bit above the wider operand so the sum cannot overflow
    localparam int SUM_W = ((CNT_W > 8) ? CNT_W : 8) + 1;
    localparam logic [SUM_W-1:0] MAX_SUM = SUM_W'({CNT_W{1'b1}});

    logic [CNT_W-1:0] r_count;
    logic [SUM_W-1:0] w_sum;

    always_comb begin
        w_sum = SUM_W'(r_count) + SUM_W'(i_inc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= (w_sum > MAX_SUM) ? '1 : w_sum[CNT_W-1:0];
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/rx_work_assembler.sv
// rx_work_assembler
// Shifts UART bytes into a WORK_BYTES-wide unit, presents full units on a
// valid/ready handshake and reports bytes lost to overrun or short packets.
//   clk, rst_n      : clock, asynchronous active-low reset
//   rx_data_ready   : strobe, rx_data valid
//   rx_data         : received byte
//   rx_endofpacket  : strobe, line idle after traffic (drops a partial unit)
//   work            : unit handshake (master side)
//   short_pkt       : pulse, partial unit discarded
//   overrun         : pulse, byte dropped while a unit is held
//   drop_cnt        : saturating count of dropped bytes
//   busy            : a partial unit is in progress or a unit is held
module rx_work_assembler
    import rx_work_assembler_pkg::*;
#(
    parameter int WORK_BYTES = WORK_BYTES_DEF,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_data_ready,
    input  logic [7:0]           rx_data,
    input  logic                 rx_endofpacket,
    rx_work_assembler_if.master  work,
    output logic                 short_pkt,
    output logic                 overrun,
    output logic [CNT_W-1:0]     drop_cnt,
    output logic                 busy
);
    localparam int CW = byteCntWidth(WORK_BYTES);
    localparam logic [CW-1:0] LAST_IDX = CW'(WORK_BYTES - 1);

    state_t                  r_state;
    logic [CW-1:0]           r_byteCnt;
    logic [8*WORK_BYTES-1:0] r_workData;
    logic                    r_workValid;
    logic                    r_shortPkt;
    logic                    r_overrun;
    logic                    r_busy;

    logic                    w_dropEn;
    logic [7:0]              w_dropInc;

    // Drop accounting: one byte on overrun, the whole partial unit on a
    // short packet. Both cases are mutually exclusive by state.
    always_comb begin
        w_dropEn  = 1'b0;
        w_dropInc = 8'd0;
        if (r_state == HOLD) begin
            if (rx_data_ready && !work.work_ready) begin
                w_dropEn  = 1'b1;
                w_dropInc = 8'd1;
            end
        end else if (!rx_data_ready && rx_endofpacket && (r_byteCnt != '0)) begin
            w_dropEn  = 1'b1;
            w_dropInc = 8'(r_byteCnt);
        end
    end

    // FSM plus shift register; every output is a register updated here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= COLLECT;
            r_byteCnt   <= '0;
            r_workData  <= '0;
            r_workValid <= 1'b0;
            r_shortPkt  <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_shortPkt <= 1'b0;
            r_overrun  <= 1'b0;
            case (r_state)
                COLLECT: begin
                    // A byte always wins over a coincident end-of-packet
                    if (rx_data_ready) begin
                        r_workData <= {r_workData[8*WORK_BYTES-9:0], rx_data};
                        r_busy     <= 1'b1;
                        if (r_byteCnt == LAST_IDX) begin
                            r_state     <= HOLD;
                            r_byteCnt   <= '0;
                            r_workValid <= 1'b1;
                        end else begin
                            r_byteCnt <= r_byteCnt + CW'(1);
                        end
                    end else if (rx_endofpacket && (r_byteCnt != '0)) begin
                        r_byteCnt  <= '0;
                        r_shortPkt <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                HOLD: begin
                    if (work.work_ready) begin
                        r_state     <= COLLECT;
                        r_workValid <= 1'b0;
                        // Byte arriving on the handshake starts the next unit
                        if (rx_data_ready) begin
                            r_workData <= {r_workData[8*WORK_BYTES-9:0], rx_data};
                            r_byteCnt  <= CW'(1);
                            r_busy     <= 1'b1;
                        end else begin
                            r_busy <= 1'b0;
                        end
                    end else if (rx_data_ready) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_dropCnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_dropEn),
        .i_inc   (w_dropInc),
        .o_count (drop_cnt)
    );

    assign work.work_valid = r_workValid;
    assign work.work_data  = r_workData;
    assign short_pkt       = r_shortPkt;
    assign overrun         = r_overrun;
    assign busy            = r_busy;
endmodule
